fsm1_mem_responder: RTL and testbench



---
 rtl/fsm1_mem_responder_if.sv | 29 ++
 rtl/fsm1_mem_responder.sv | 80 ++++++++
 tb/tb_fsm1_mem_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm1_mem_responder_if.sv
// Read-handshake bus between the fsm1_reg controller side and the memory
// responder, plus the preload write port for the responder's register file.
interface fsm1_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
);
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wait_cfg;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              ws;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  // Controller / preload side: issues reads and writes, observes the reply.
  modport master (
    output rd, addr, wait_cfg, we, waddr, wdata,
    input  ws, rdata, rvalid
  );

  // Responder side: receives reads and writes, produces the reply.
  modport slave (
    input  rd, addr, wait_cfg, we, waddr, wdata,
    output ws, rdata, rvalid
  );
endinterface

// File: rtl/fsm1_mem_responder.sv
// Memory-side responder for the go/rd/ws/ds read handshake. A read strobe
// captures the address and a wait count, ws is held high while the count
// drains, then the addressed word is loaded and flagged valid until the
// controller drops rd.
module fsm1_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic clock,
  input  logic reset,
  fsm1_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Access sequencer: capture on rd, count down the wait states, load the
  // word once the count is exhausted, then hold until rd is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd) begin
            state  <= BUSY;
            addr_q <= bus.addr;
            cnt    <= bus.wait_cfg;
          end
        end
        BUSY: begin
          if (!bus.rd) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state   <= READY;
            rdata_q <= mem[addr_q];
          end
        end
        READY: begin
          if (!bus.rd) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Preload port: writes land in any state and are not reset; a read
  // loading on the same edge sees the old word.
  always_ff @(posedge clock) begin
    if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.ws     = (state == BUSY) && (cnt != '0);
  assign bus.rvalid = (state == READY);
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_fsm1_mem_responder.sv
// Bench for fsm1_mem_responder: a behavioural fsm1_reg controller drives
// table-driven reads, and hand-written sequences cover abort, read/write
// collision and reset in the middle of an access.
module tb_fsm1_mem_responder;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  typedef enum logic [1:0] {C_IDLE, C_READ, C_DLY, C_DONE} ctrl_t;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] cfg;
    logic [7:0] data;
    int         wsCycles;
    int         reads;
  } vec_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  logic  useCtrl = 1'b0;
  logic  manualRd = 1'b0;
  logic  ctrlGo = 1'b0;
  ctrl_t ctrlState;
  logic  ctrlRd;

  int checks = 0;
  int errors = 0;

  vec_t vecs [6];

  fsm1_mem_responder_if ifc ();

  fsm1_mem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  // Behavioural fsm1_reg read controller sitting opposite the responder.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrlState <= C_IDLE;
    end else begin
      case (ctrlState)
        C_IDLE:  if (ctrlGo) ctrlState <= C_READ;
        C_READ:  ctrlState <= C_DLY;
        C_DLY:   ctrlState <= ifc.ws ? C_READ : C_DONE;
        default: ctrlState <= C_IDLE;
      endcase
    end
  end

  assign ctrlRd = (ctrlState == C_READ) || (ctrlState == C_DLY);

  // Read strobe comes from the controller model or from a hand sequence.
  always_comb begin
    ifc.rd = useCtrl ? ctrlRd : manualRd;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic writeMem(input logic [3:0] a, input logic [7:0] d);
    ifc.we    = 1'b1;
    ifc.waddr = a;
    ifc.wdata = d;
    @(negedge clock);
    ifc.we    = 1'b0;
  endtask

  // Full read through the controller model; entered and left on a negedge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] cfg,
                               input logic [7:0] expData, input int expWs,
                               input int expReads);
    int  wsCycles;
    int  busyCycles;
    int  readCycles;
    bit  done;
    wsCycles   = 0;
    busyCycles = 0;
    readCycles = 0;
    done       = 1'b0;
    useCtrl      = 1'b1;
    ifc.addr     = a;
    ifc.wait_cfg = cfg;
    ctrlGo       = 1'b1;
    @(negedge clock);
    ctrlGo = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (ifc.ws) wsCycles++;
      if (dut.state == S_BUSY) busyCycles++;
      if (ctrlState == C_READ) readCycles++;
      if (ctrlState == C_DONE) begin
        checkOutput("done_rvalid", 32'(ifc.rvalid), 32'd1);
        checkOutput("done_rdata", 32'(ifc.rdata), 32'(expData));
        done = 1'b1;
      end
      @(negedge clock);
    end
    checkOutput("read_timeout", 32'(done), 32'd1);
    checkOutput("ws_cycles", 32'(wsCycles), 32'(expWs));
    checkOutput("busy_cycles", 32'(busyCycles), 32'(int'(cfg) + 1));
    checkOutput("read_visits", 32'(readCycles), 32'(expReads));
    checkOutput("idle_after", 32'(dut.state), 32'(S_IDLE));
    checkOutput("rvalid_after", 32'(ifc.rvalid), 32'd0);
    useCtrl = 1'b0;
  endtask

  initial begin
    ifc.addr     = '0;
    ifc.wait_cfg = '0;
    ifc.we       = 1'b0;
    ifc.waddr    = '0;
    ifc.wdata    = '0;

    vecs[0] = '{addr: 4'd3,  cfg: 4'd0,  data: 8'hA5, wsCycles: 0,  reads: 1};
    vecs[1] = '{addr: 4'd3,  cfg: 4'd2,  data: 8'hA5, wsCycles: 2,  reads: 2};
    vecs[2] = '{addr: 4'd9,  cfg: 4'd1,  data: 8'h3C, wsCycles: 1,  reads: 2};
    vecs[3] = '{addr: 4'd15, cfg: 4'd4,  data: 8'hFF, wsCycles: 4,  reads: 3};
    vecs[4] = '{addr: 4'd0,  cfg: 4'd3,  data: 8'h5A, wsCycles: 3,  reads: 3};
    vecs[5] = '{addr: 4'd9,  cfg: 4'd15, data: 8'h3C, wsCycles: 15, reads: 9};

    // Reset state
    #20;
    checkOutput("rst_state", 32'(dut.state), 32'(S_IDLE));
    checkOutput("rst_ws", 32'(ifc.ws), 32'd0);
    checkOutput("rst_rvalid", 32'(ifc.rvalid), 32'd0);
    checkOutput("rst_rdata", 32'(ifc.rdata), 32'd0);
    checkOutput("rst_cnt", 32'(dut.cnt), 32'd0);
    checkOutput("rst_addr_q", 32'(dut.addr_q), 32'd0);
    #80;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Preload
    writeMem(4'd3, 8'hA5);
    checkOutput("preload_mem3", 32'(dut.mem[3]), 32'hA5);
    writeMem(4'd9, 8'h3C);
    writeMem(4'd15, 8'hFF);
    writeMem(4'd0, 8'h5A);

    // Table-driven reads through the controller
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].cfg, vecs[i].data,
                    vecs[i].wsCycles, vecs[i].reads);
    end

    // Abort in the second BUSY cycle
    begin
      bit sawValid;
      sawValid     = 1'b0;
      ifc.addr     = 4'd3;
      ifc.wait_cfg = 4'd5;
      manualRd     = 1'b1;
      @(negedge clock);
      checkOutput("abort_busy1", 32'(dut.state), 32'(S_BUSY));
      checkOutput("abort_ws1", 32'(ifc.ws), 32'd1);
      if (ifc.rvalid) sawValid = 1'b1;
      @(negedge clock);
      checkOutput("abort_busy2", 32'(dut.state), 32'(S_BUSY));
      if (ifc.rvalid) sawValid = 1'b1;
      manualRd = 1'b0;
      @(negedge clock);
      checkOutput("abort_idle", 32'(dut.state), 32'(S_IDLE));
      if (ifc.rvalid) sawValid = 1'b1;
      @(negedge clock);
      if (ifc.rvalid) sawValid = 1'b1;
      checkOutput("abort_no_rvalid", 32'(sawValid), 32'd0);
      checkOutput("abort_rdata_kept", 32'(ifc.rdata), 32'(vecs[5].data));
    end

    // Read/write collision on the READY-entry edge, wait_cfg changed mid-access
    writeMem(4'd7, 8'h11);
    ifc.addr     = 4'd7;
    ifc.wait_cfg = 4'd1;
    manualRd     = 1'b1;
    @(negedge clock);
    checkOutput("coll_ws1", 32'(ifc.ws), 32'd1);
    ifc.wait_cfg = 4'd9;
    @(negedge clock);
    checkOutput("coll_cfg_ignored_ws", 32'(ifc.ws), 32'd0);
    checkOutput("coll_busy", 32'(dut.state), 32'(S_BUSY));
    ifc.we    = 1'b1;
    ifc.waddr = 4'd7;
    ifc.wdata = 8'h22;
    @(negedge clock);
    ifc.we = 1'b0;
    checkOutput("coll_rvalid", 32'(ifc.rvalid), 32'd1);
    checkOutput("coll_old_word", 32'(ifc.rdata), 32'h11);
    manualRd = 1'b0;
    @(negedge clock);
    checkOutput("coll_idle", 32'(dut.state), 32'(S_IDLE));
    applyStimulus(4'd7, 4'd0, 8'h22, 0, 1);

    // Reset between clock edges while BUSY with ws high
    ifc.addr     = 4'd3;
    ifc.wait_cfg = 4'd6;
    manualRd     = 1'b1;
    @(negedge clock);
    checkOutput("mid_ws_before", 32'(ifc.ws), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_ws", 32'(ifc.ws), 32'd0);
    checkOutput("mid_state", 32'(dut.state), 32'(S_IDLE));
    checkOutput("mid_rvalid", 32'(ifc.rvalid), 32'd0);
    checkOutput("mid_rdata", 32'(ifc.rdata), 32'd0);
    manualRd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(4'd3, 4'd2, 8'hA5, 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
